// File: rtl/rv_pkg.sv
// Shared RV64 execute-stage types: ALU op encoding, funct3 codes and
// the internal ALU control enum.
package rv_pkg;

   typedef enum logic [1:0] {
      ALU_OP_ADD   = 2'b00,
      ALU_OP_SUB   = 2'b01,
      ALU_OP_FUNCT = 2'b10
   } alu_op_e;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND
   } alu_ctrl_e;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU. Shift amounts use the low log2(XLEN) bits of b;
// zero flags an all-zero result (used for beq via subtraction).
module alu
   import rv_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  alu_ctrl_e         i_ctrl,
   input  logic [XLEN-1:0]   i_a,
   input  logic [XLEN-1:0]   i_b,
   output logic [XLEN-1:0]   o_result,
   output logic              o_zero
);

   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0] shamt;
   assign shamt = i_b[SHW-1:0];

   // Operation select
   always_comb begin
      o_result = '0;
      case (i_ctrl)
         ALU_ADD:  o_result = i_a + i_b;
         ALU_SUB:  o_result = i_a - i_b;
         ALU_SLL:  o_result = i_a << shamt;
         ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
         ALU_XOR:  o_result = i_a ^ i_b;
         ALU_SRL:  o_result = i_a >> shamt;
         ALU_SRA:  o_result = $signed(i_a) >>> shamt;
         ALU_OR:   o_result = i_a | i_b;
         ALU_AND:  o_result = i_a & i_b;
         default:  o_result = '0;
      endcase
   end

   assign o_zero = (o_result == '0);

endmodule

// File: rtl/execute_stage.sv
// RV64 execute stage: operand select, ALU, beq evaluation, branch target,
// and the EX/MEM pipeline register with a one-cycle redirect to fetch.
// Optional operand forwarding from EX/MEM and MEM/WB: RV_EX_FORWARDING_EN.
module execute_stage
   import rv_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic [31:0]       i_idex_instruction,
   input  logic [XLEN-1:0]   i_idex_rs1_value,
   input  logic [XLEN-1:0]   i_idex_rs2_value,
   input  logic [XLEN-1:0]   i_idex_immediate,
   input  logic [XLEN-1:0]   i_idex_pc,
   input  logic [1:0]        i_idex_alu_op,
   input  logic              i_idex_alu_src,
   input  logic              i_idex_branch,
   input  logic              i_idex_mem_write,
   input  logic              i_idex_mem_read,
   input  logic              i_idex_mem_to_reg,
   input  logic              i_idex_reg_write,
   input  logic [4:0]        i_memwb_rd,
   input  logic              i_memwb_reg_write,
   input  logic [XLEN-1:0]   i_memwb_value,
   output logic [XLEN-1:0]   o_exmem_alu_result,
   output logic [XLEN-1:0]   o_exmem_rs2_value,
   output logic [4:0]        o_exmem_rd,
   output logic [XLEN-1:0]   o_exmem_pc,
   output logic              o_exmem_mem_write,
   output logic              o_exmem_mem_read,
   output logic              o_exmem_mem_to_reg,
   output logic              o_exmem_reg_write,
   output logic              o_branch_taken,
   output logic [XLEN-1:0]   o_branch_target
);

   logic [4:0] rd_idx;
   logic [2:0] funct3;
   logic       funct7_b5;

   assign rd_idx    = i_idex_instruction[11:7];
   assign funct3    = i_idex_instruction[14:12];
   assign funct7_b5 = i_idex_instruction[30];

   logic [XLEN-1:0] alu_result_d, alu_result_q;
   logic [XLEN-1:0] rs2_value_d, rs2_value_q;
   logic [4:0]      rd_d, rd_q;
   logic [XLEN-1:0] pc_d, pc_q;
   logic            mem_write_d, mem_write_q;
   logic            mem_read_d, mem_read_q;
   logic            mem_to_reg_d, mem_to_reg_q;
   logic            reg_write_d, reg_write_q;
   logic            branch_taken_d, branch_taken_q;
   logic [XLEN-1:0] branch_target_d, branch_target_q;

   logic [XLEN-1:0] fwd_rs1, fwd_rs2;

`ifdef RV_EX_FORWARDING_EN
   logic [4:0] rs1_idx, rs2_idx;
   assign rs1_idx = i_idex_instruction[19:15];
   assign rs2_idx = i_idex_instruction[24:20];

   // EX/MEM result has priority over MEM/WB; x0 is never forwarded
   always_comb begin
      fwd_rs1 = i_idex_rs1_value;
      fwd_rs2 = i_idex_rs2_value;
      if (rs1_idx != 5'd0) begin
         if (reg_write_q && (rd_q == rs1_idx))
            fwd_rs1 = alu_result_q;
         else if (i_memwb_reg_write && (i_memwb_rd == rs1_idx))
            fwd_rs1 = i_memwb_value;
      end
      if (rs2_idx != 5'd0) begin
         if (reg_write_q && (rd_q == rs2_idx))
            fwd_rs2 = alu_result_q;
         else if (i_memwb_reg_write && (i_memwb_rd == rs2_idx))
            fwd_rs2 = i_memwb_value;
      end
   end

   logic unused_instr_bits;
   assign unused_instr_bits = ^{i_idex_instruction[31], i_idex_instruction[29:25],
                                i_idex_instruction[6:0]};
`else
   assign fwd_rs1 = i_idex_rs1_value;
   assign fwd_rs2 = i_idex_rs2_value;

   logic unused_instr_bits;
   assign unused_instr_bits = ^{i_idex_instruction[31], i_idex_instruction[29:15],
                                i_idex_instruction[6:0], i_memwb_rd,
                                i_memwb_reg_write, i_memwb_value};
`endif

   alu_ctrl_e       alu_ctrl;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;

   // A branch always runs rs1-rs2 through the ALU so beq can use the zero flag
   assign op_b = (i_idex_alu_src && !i_idex_branch) ? i_idex_immediate : fwd_rs2;

   // ALU control decode from alu_op and funct3/funct7[5]
   always_comb begin
      alu_ctrl = ALU_ADD;
      if (i_idex_branch) begin
         alu_ctrl = ALU_SUB;
      end else begin
         case (i_idex_alu_op)
            ALU_OP_SUB: alu_ctrl = ALU_SUB;
            ALU_OP_FUNCT: begin
               case (funct3)
                  F3_ADD_SUB: alu_ctrl = funct7_b5 ? ALU_SUB : ALU_ADD;
                  F3_SLL:     alu_ctrl = ALU_SLL;
                  F3_SLT:     alu_ctrl = ALU_SLT;
                  F3_SLTU:    alu_ctrl = ALU_SLTU;
                  F3_XOR:     alu_ctrl = ALU_XOR;
                  F3_SRL_SRA: alu_ctrl = funct7_b5 ? ALU_SRA : ALU_SRL;
                  F3_OR:      alu_ctrl = ALU_OR;
                  F3_AND:     alu_ctrl = ALU_AND;
                  default:    alu_ctrl = ALU_ADD;
               endcase
            end
            default: alu_ctrl = ALU_ADD;
         endcase
      end
   end

   alu #(.XLEN(XLEN)) u_alu (
      .i_ctrl   (alu_ctrl),
      .i_a      (fwd_rs1),
      .i_b      (op_b),
      .o_result (alu_result),
      .o_zero   (alu_zero)
   );

   // EX/MEM next state: flush beats stall, stall holds everything
   always_comb begin
      alu_result_d    = alu_result_q;
      rs2_value_d     = rs2_value_q;
      rd_d            = rd_q;
      pc_d            = pc_q;
      mem_write_d     = mem_write_q;
      mem_read_d      = mem_read_q;
      mem_to_reg_d    = mem_to_reg_q;
      reg_write_d     = reg_write_q;
      branch_taken_d  = branch_taken_q;
      branch_target_d = branch_target_q;
      if (i_flush) begin
         mem_write_d    = 1'b0;
         mem_read_d     = 1'b0;
         mem_to_reg_d   = 1'b0;
         reg_write_d    = 1'b0;
         branch_taken_d = 1'b0;
      end else if (!i_stall) begin
         alu_result_d    = alu_result;
         rs2_value_d     = fwd_rs2;
         rd_d            = rd_idx;
         pc_d            = i_idex_pc;
         mem_write_d     = i_idex_mem_write;
         mem_read_d      = i_idex_mem_read;
         mem_to_reg_d    = i_idex_mem_to_reg;
         reg_write_d     = i_idex_reg_write;
         branch_taken_d  = i_idex_branch & alu_zero;
         branch_target_d = i_idex_pc + i_idex_immediate;
      end
   end

   // EX/MEM pipeline register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         alu_result_q    <= '0;
         rs2_value_q     <= '0;
         rd_q            <= '0;
         pc_q            <= RESET_PC;
         mem_write_q     <= 1'b0;
         mem_read_q      <= 1'b0;
         mem_to_reg_q    <= 1'b0;
         reg_write_q     <= 1'b0;
         branch_taken_q  <= 1'b0;
         branch_target_q <= RESET_PC;
      end else begin
         alu_result_q    <= alu_result_d;
         rs2_value_q     <= rs2_value_d;
         rd_q            <= rd_d;
         pc_q            <= pc_d;
         mem_write_q     <= mem_write_d;
         mem_read_q      <= mem_read_d;
         mem_to_reg_q    <= mem_to_reg_d;
         reg_write_q     <= reg_write_d;
         branch_taken_q  <= branch_taken_d;
         branch_target_q <= branch_target_d;
      end
   end

   assign o_exmem_alu_result = alu_result_q;
   assign o_exmem_rs2_value  = rs2_value_q;
   assign o_exmem_rd         = rd_q;
   assign o_exmem_pc         = pc_q;
   assign o_exmem_mem_write  = mem_write_q;
   assign o_exmem_mem_read   = mem_read_q;
   assign o_exmem_mem_to_reg = mem_to_reg_q;
   assign o_exmem_reg_write  = reg_write_q;
   assign o_branch_taken     = branch_taken_q;
   assign o_branch_target    = branch_target_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; forwarding cases build only with RV_EX_FORWARDING_EN.
module tb_execute_stage;
   import rv_pkg::*;

   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
   localparam logic [6:0]  OPC_R  = 7'b0110011;

   logic        i_clk   = 1'b0;
   logic        i_rst_n = 1'b1;
   logic        i_stall, i_flush;
   logic [31:0] i_idex_instruction;
   logic [63:0] i_idex_rs1_value, i_idex_rs2_value, i_idex_immediate, i_idex_pc;
   logic [1:0]  i_idex_alu_op;
   logic        i_idex_alu_src, i_idex_branch, i_idex_mem_write, i_idex_mem_read;
   logic        i_idex_mem_to_reg, i_idex_reg_write;
   logic [4:0]  i_memwb_rd;
   logic        i_memwb_reg_write;
   logic [63:0] i_memwb_value;
   logic [63:0] o_exmem_alu_result, o_exmem_rs2_value, o_exmem_pc, o_branch_target;
   logic [4:0]  o_exmem_rd;
   logic        o_exmem_mem_write, o_exmem_mem_read, o_exmem_mem_to_reg, o_exmem_reg_write;
   logic        o_branch_taken;

   int n_chk = 0;
   int n_bad = 0;

   always #5 i_clk = ~i_clk;

   execute_stage #(.XLEN(64), .RESET_PC(RST_PC)) dut (
      .i_clk              (i_clk),
      .i_rst_n            (i_rst_n),
      .i_stall            (i_stall),
      .i_flush            (i_flush),
      .i_idex_instruction (i_idex_instruction),
      .i_idex_rs1_value   (i_idex_rs1_value),
      .i_idex_rs2_value   (i_idex_rs2_value),
      .i_idex_immediate   (i_idex_immediate),
      .i_idex_pc          (i_idex_pc),
      .i_idex_alu_op      (i_idex_alu_op),
      .i_idex_alu_src     (i_idex_alu_src),
      .i_idex_branch      (i_idex_branch),
      .i_idex_mem_write   (i_idex_mem_write),
      .i_idex_mem_read    (i_idex_mem_read),
      .i_idex_mem_to_reg  (i_idex_mem_to_reg),
      .i_idex_reg_write   (i_idex_reg_write),
      .i_memwb_rd         (i_memwb_rd),
      .i_memwb_reg_write  (i_memwb_reg_write),
      .i_memwb_value      (i_memwb_value),
      .o_exmem_alu_result (o_exmem_alu_result),
      .o_exmem_rs2_value  (o_exmem_rs2_value),
      .o_exmem_rd         (o_exmem_rd),
      .o_exmem_pc         (o_exmem_pc),
      .o_exmem_mem_write  (o_exmem_mem_write),
      .o_exmem_mem_read   (o_exmem_mem_read),
      .o_exmem_mem_to_reg (o_exmem_mem_to_reg),
      .o_exmem_reg_write  (o_exmem_reg_write),
      .o_branch_taken     (o_branch_taken),
      .o_branch_target    (o_branch_target)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic f7b5, input logic [2:0] f3,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] rd, input logic [6:0] opc);
      return {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, opc};
   endfunction

   // ctl = {branch, mem_write, mem_read, mem_to_reg, reg_write}
   task automatic drive(input logic [31:0] instr, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] imm, input logic [63:0] pc,
                        input logic [1:0] aop, input logic asrc, input logic [4:0] ctl);
      i_idex_instruction = instr;
      i_idex_rs1_value   = a;
      i_idex_rs2_value   = b;
      i_idex_immediate   = imm;
      i_idex_pc          = pc;
      i_idex_alu_op      = aop;
      i_idex_alu_src     = asrc;
      {i_idex_branch, i_idex_mem_write, i_idex_mem_read, i_idex_mem_to_reg, i_idex_reg_write} = ctl;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk_ctl(input string tag, input logic [3:0] exp);
      chk(tag, {60'b0, o_exmem_mem_write, o_exmem_mem_read, o_exmem_mem_to_reg, o_exmem_reg_write},
          {60'b0, exp});
   endtask

   initial begin
      i_stall = 0; i_flush = 0;
      i_memwb_rd = 0; i_memwb_reg_write = 0; i_memwb_value = 0;
      drive(32'h0, 0, 0, 0, 0, 2'b00, 0, 5'b00000);
      #1 i_rst_n = 1'b0;
      #11;
      chk("rst_result", o_exmem_alu_result, 64'h0);
      chk("rst_pc", o_exmem_pc, RST_PC);
      chk("rst_target", o_branch_target, RST_PC);
      chk("rst_taken", {63'b0, o_branch_taken}, 64'h0);
      chk_ctl("rst_ctl", 4'b0000);
      i_rst_n = 1'b1;

      // R-type sub
      drive(enc(1, 3'b000, 1, 2, 10, OPC_R), 5, 7, 0, 64'h40, 2'b10, 0, 5'b00001);
      tick();
      chk("sub", o_exmem_alu_result, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("sub_rw", {63'b0, o_exmem_reg_write}, 64'h1);
      chk("sub_rd", {59'b0, o_exmem_rd}, 64'd10);
      chk("sub_pc", o_exmem_pc, 64'h40);

      // sra / srl / sll with amount above 63 using only low 6 bits
      drive(enc(1, 3'b101, 1, 2, 11, OPC_R), 64'h8000_0000_0000_0000, 4, 0, 0, 2'b10, 0, 5'b00001);
      tick();
      chk("sra", o_exmem_alu_result, 64'hF800_0000_0000_0000);
      drive(enc(0, 3'b101, 1, 2, 11, OPC_R), 64'h8000_0000_0000_0000, 4, 0, 0, 2'b10, 0, 5'b00001);
      tick();
      chk("srl", o_exmem_alu_result, 64'h0800_0000_0000_0000);
      drive(enc(0, 3'b001, 1, 2, 11, OPC_R), 1, 65, 0, 0, 2'b10, 0, 5'b00001);
      tick();
      chk("sll", o_exmem_alu_result, 64'h2);

      // compare / logic ops
      drive(enc(0, 3'b010, 1, 2, 12, OPC_R), 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 2'b10, 0, 5'b00001);
      tick();
      chk("slt", o_exmem_alu_result, 64'h1);
      drive(enc(0, 3'b011, 1, 2, 12, OPC_R), 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 2'b10, 0, 5'b00001);
      tick();
      chk("sltu", o_exmem_alu_result, 64'h0);
      drive(enc(0, 3'b100, 1, 2, 12, OPC_R), 64'hF0, 64'hFF, 0, 0, 2'b10, 0, 5'b00001);
      tick();
      chk("xor", o_exmem_alu_result, 64'h0F);
      drive(enc(0, 3'b110, 1, 2, 12, OPC_R), 64'hF0, 64'h0F, 0, 0, 2'b10, 0, 5'b00001);
      tick();
      chk("or", o_exmem_alu_result, 64'hFF);
      drive(enc(0, 3'b111, 1, 2, 12, OPC_R), 64'hF0, 64'h3C, 0, 0, 2'b10, 0, 5'b00001);
      tick();
      chk("and", o_exmem_alu_result, 64'h30);
      drive(enc(0, 3'b000, 1, 2, 12, OPC_R), 64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 0, 2'b10, 0, 5'b00001);
      tick();
      chk("add_wrap", o_exmem_alu_result, 64'h1);

      // alu_op 01 and 11 ignore funct bits
      drive(enc(0, 3'b111, 1, 2, 13, OPC_R), 0, 1, 0, 0, 2'b01, 0, 5'b00001);
      tick();
      chk("op01_sub", o_exmem_alu_result, 64'hFFFF_FFFF_FFFF_FFFF);
      drive(enc(1, 3'b100, 1, 2, 13, OPC_R), 3, 4, 0, 0, 2'b11, 0, 5'b00001);
      tick();
      chk("op11_add", o_exmem_alu_result, 64'h7);

      // beq taken, then held across a stall, then not-equal
      drive(enc(0, 3'b000, 1, 2, 0, OPC_BRANCH), 9, 9, 64'hFFFF_FFFF_FFFF_FFF8, 64'h100, 2'b01, 0, 5'b10000);
      tick();
      chk("beq_taken", {63'b0, o_branch_taken}, 64'h1);
      chk("beq_target", o_branch_target, 64'hF8);
      chk_ctl("beq_ctl", 4'b0000);
      i_stall = 1;
      drive(enc(0, 3'b000, 1, 2, 0, OPC_BRANCH), 1, 2, 64'h4, 64'h200, 2'b01, 0, 5'b10000);
      tick();
      chk("stall_taken", {63'b0, o_branch_taken}, 64'h1);
      chk("stall_target", o_branch_target, 64'hF8);
      i_stall = 0;
      tick();
      chk("bne_taken", {63'b0, o_branch_taken}, 64'h0);
      chk("bne_target", o_branch_target, 64'h204);
      drive(enc(0, 3'b000, 1, 2, 0, OPC_BRANCH), 5, 5, 64'h4, 64'h200, 2'b01, 0, 5'b00000);
      tick();
      chk("nobranch_taken", {63'b0, o_branch_taken}, 64'h0);
      drive(enc(0, 3'b000, 1, 2, 0, OPC_BRANCH), 5, 5, 64'h20, 64'hFFFF_FFFF_FFFF_FFF0, 2'b01, 0, 5'b10000);
      tick();
      chk("wrap_taken", {63'b0, o_branch_taken}, 64'h1);
      chk("wrap_target", o_branch_target, 64'h10);
      i_stall = 1; i_flush = 1;
      tick();
      chk("flush_taken", {63'b0, o_branch_taken}, 64'h0);
      i_stall = 0; i_flush = 0;

      // load, held for three stalled cycles, then flushed while stalled
      drive(enc(0, 3'b000, 1, 2, 14, 7'b0000011), 64'h1000, 0, 64'h10, 64'h300, 2'b00, 1, 5'b00111);
      tick();
      chk("ld_result", o_exmem_alu_result, 64'h1010);
      chk_ctl("ld_ctl", 4'b0111);
      i_stall = 1;
      drive(enc(0, 3'b000, 1, 2, 15, OPC_R), 64'h55, 64'h66, 64'h1, 64'h400, 2'b00, 0, 5'b01000);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_result", o_exmem_alu_result, 64'h1010);
         chk_ctl("stall_ctl", 4'b0111);
      end
      chk("stall_rd", {59'b0, o_exmem_rd}, 64'd14);
      i_flush = 1;
      tick();
      chk_ctl("flush_ctl", 4'b0000);
      i_stall = 0; i_flush = 0;

      // bubble passes through as a bubble
      drive(32'h0, 64'h7, 64'h7, 0, 0, 2'b00, 0, 5'b00000);
      tick();
      chk_ctl("bubble_ctl", 4'b0000);
      chk("bubble_taken", {63'b0, o_branch_taken}, 64'h0);

      // async reset between edges, then a normal load on the first edge after release
      drive(enc(0, 3'b000, 1, 2, 0, OPC_BRANCH), 3, 3, 64'h8, 64'h500, 2'b01, 0, 5'b10001);
      tick();
      chk("pre_rst_taken", {63'b0, o_branch_taken}, 64'h1);
      #2 i_rst_n = 1'b0;
      #1;
      chk("arst_taken", {63'b0, o_branch_taken}, 64'h0);
      chk("arst_pc", o_exmem_pc, RST_PC);
      chk("arst_target", o_branch_target, RST_PC);
      chk("arst_result", o_exmem_alu_result, 64'h0);
      chk_ctl("arst_ctl", 4'b0000);
      #2 i_rst_n = 1'b1;
      drive(enc(0, 3'b000, 1, 2, 16, OPC_R), 3, 4, 0, 64'h600, 2'b11, 0, 5'b00001);
      tick();
      chk("post_rst_result", o_exmem_alu_result, 64'h7);
      chk_ctl("post_rst_ctl", 4'b0001);

`ifdef RV_EX_FORWARDING_EN
      drive(enc(0, 3'b000, 1, 2, 3, OPC_R), 10, 20, 0, 0, 2'b10, 0, 5'b00001);
      tick();
      chk("fw_x3", o_exmem_alu_result, 64'd30);
      drive(enc(0, 3'b000, 3, 3, 4, OPC_R), 0, 0, 0, 0, 2'b10, 0, 5'b00001);
      tick();
      chk("fw_exmem", o_exmem_alu_result, 64'd60);
      chk("fw_store", o_exmem_rs2_value, 64'd30);
      i_memwb_rd = 6; i_memwb_reg_write = 1; i_memwb_value = 7;
      drive(enc(0, 3'b000, 6, 6, 5, OPC_R), 0, 0, 0, 0, 2'b10, 0, 5'b00001);
      tick();
      chk("fw_memwb", o_exmem_alu_result, 64'd14);
      i_memwb_rd = 5; i_memwb_value = 100;
      drive(enc(0, 3'b000, 5, 5, 7, OPC_R), 0, 0, 0, 0, 2'b10, 0, 5'b00001);
      tick();
      chk("fw_prio", o_exmem_alu_result, 64'd28);
      i_memwb_reg_write = 0;
      drive(enc(0, 3'b000, 7, 7, 9, OPC_R), 0, 0, 64'd1, 0, 2'b00, 1, 5'b00001);
      tick();
      chk("fw_imm", o_exmem_alu_result, 64'd29);
      chk("fw_imm_store", o_exmem_rs2_value, 64'd28);
      drive(enc(0, 3'b000, 1, 2, 0, OPC_R), 1, 2, 0, 0, 2'b10, 0, 5'b00001);
      tick();
      chk("fw_x0_write", o_exmem_alu_result, 64'd3);
      i_memwb_rd = 0; i_memwb_reg_write = 1; i_memwb_value = 55;
      drive(enc(0, 3'b000, 0, 0, 8, OPC_R), 0, 0, 0, 0, 2'b10, 0, 5'b00001);
      tick();
      chk("fw_x0", o_exmem_alu_result, 64'd0);
      i_memwb_reg_write = 0;
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
